bundle_coupler: RTL and testbench

BUNDLE_COUPLER -- requirements
Module: bundle_coupler

---
 rtl/bundle_coupler.sv | 100 ++++++++++
 tb/tb_bundle_coupler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bundle_coupler.sv
// Pairs consecutive input bundles into double-width words and queues them in a show-ahead FIFO.
// Optional sticky overflow flag on o_err is compiled in with `define COUPLER_OVF_CHK_EN.
module bundle_coupler #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUNDLE_WIDTH = 8,
  parameter int DEPTH        = 16,
  parameter int FULL_SLACK   = 6
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [DATA_WIDTH*BUNDLE_WIDTH:0]     i_data,
  input  logic                                 i_write,
  output logic                                 o_full,
  output logic [2*DATA_WIDTH*BUNDLE_WIDTH:0]   o_data,
  output logic                                 o_data_vld,
  input  logic                                 i_read,
  output logic                                 o_err
);

  localparam int BW = DATA_WIDTH * BUNDLE_WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_MAX  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH - FULL_SLACK);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [BW-1:0]   lo_q;
  logic            half_vld_q, half_vld_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [2*BW:0]   mem [DEPTH];

  logic            in_last;
  logic [BW-1:0]   in_bundle;
  logic            push_req, push, pop;
  logic [2*BW:0]   push_word;

  assign in_last   = i_data[BW];
  assign in_bundle = i_data[BW-1:0];

  // Output handshake: o_data is valid whenever o_data_vld=1; the head is consumed on a
  // rising edge where i_read=1 and o_data_vld=1. Upstream has no ready: it must honour o_full.
  always_comb begin
    push_req  = i_write && (half_vld_q || in_last);
    // An unpaired last bundle is padded with max keys in the second half.
    push_word = half_vld_q ? {in_last, in_bundle, lo_q} : {1'b1, {BW{1'b1}}, in_bundle};
    pop       = i_read && (count_q != '0);
    push      = push_req && ((count_q != CNT_MAX) || pop);

    half_vld_d = half_vld_q;
    if (i_write) half_vld_d = !half_vld_q && !in_last;

    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      half_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      half_vld_q <= half_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage and the half register carry no reset; validity lives in count_q and half_vld_q.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
    if (i_write && !half_vld_q && !in_last) lo_q <= in_bundle;
  end

  assign o_data     = mem[rd_ptr_q];
  assign o_data_vld = (count_q != '0);
  assign o_full     = (count_q >= CNT_FULL);

`ifdef COUPLER_OVF_CHK_EN
  logic err_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              err_q <= 1'b0;
    else if (push_req && !push) err_q <= 1'b1;
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_bundle_coupler.sv
// Randomized bench for bundle_coupler: queue-based reference model, scoreboard and monitor.
module tb_bundle_coupler;
  localparam int DATA_WIDTH   = 32;
  localparam int BUNDLE_WIDTH = 8;
  localparam int DEPTH        = 16;
  localparam int FULL_SLACK   = 6;
  localparam int BW           = DATA_WIDTH * BUNDLE_WIDTH;
  localparam int W            = 2 * BW + 1;

  // clock / reset
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [BW:0]  i_data;
  logic         i_write, i_read;
  logic         o_full, o_data_vld, o_err;
  logic [W-1:0] o_data;

  bundle_coupler #(
    .DATA_WIDTH(DATA_WIDTH), .BUNDLE_WIDTH(BUNDLE_WIDTH),
    .DEPTH(DEPTH), .FULL_SLACK(FULL_SLACK)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_write(i_write),
    .o_full(o_full), .o_data(o_data), .o_data_vld(o_data_vld),
    .i_read(i_read), .o_err(o_err)
  );

  // reference model state: committed entries, pending half bundle, overflow flag
  logic [W-1:0]  exp_q[$];
  logic          m_half;
  logic [BW-1:0] m_lo;
  logic          m_err;
  int            checks;
  int            errors;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd_bundle();
    logic [BW-1:0] b;
    for (int i = 0; i < BUNDLE_WIDTH; i++) b[i*DATA_WIDTH +: DATA_WIDTH] = $urandom();
    return b;
  endfunction

  // driver: called at posedge+1, applies one cycle of stimulus and updates the model
  task automatic step(input logic wr, input logic last, input logic [BW-1:0] b, input logic rd);
    logic         req, acc;
    logic [W-1:0] word;
    int           sz;
    i_write = wr;
    i_data  = {last, b};
    i_read  = rd;
    req  = 1'b0;
    word = '0;
    if (wr) begin
      if (m_half) begin
        word   = {last, b, m_lo};
        req    = 1'b1;
        m_half = 1'b0;
      end else if (last) begin
        word = {1'b1, {BW{1'b1}}, b};
        req  = 1'b1;
      end else begin
        m_lo   = b;
        m_half = 1'b1;
      end
    end
    sz  = exp_q.size();
    acc = req && ((sz < DEPTH) || (rd && sz > 0));
    @(posedge clk);
    if (acc) exp_q.push_back(word);
`ifdef COUPLER_OVF_CHK_EN
    if (req && !acc) m_err = 1'b1;
`endif
    #1;
    i_write = 1'b0;
    i_read  = 1'b0;
  endtask

  task automatic do_reset();
    i_write = 1'b0;
    i_read  = 1'b0;
    rst_n   = 1'b0;
    exp_q.delete();
    m_half  = 1'b0;
    m_err   = 1'b0;
    #1;
    chk("rst_vld", o_data_vld, '0);
    chk("rst_full", o_full, '0);
    chk("rst_err", o_err, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("drain_left", W'(exp_q.size()), '0);
  endtask

  // monitor / scoreboard: sampled on the falling edge
  always @(negedge clk) begin
    chk("data_vld", o_data_vld, W'(exp_q.size() != 0));
    chk("full", o_full, W'(exp_q.size() >= DEPTH - FULL_SLACK));
    chk("err", o_err, W'(m_err));
    if (o_data_vld && i_read && exp_q.size() > 0) chk("data", o_data, exp_q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] b [6];
    checks  = 0;
    errors  = 0;
    m_half  = 1'b0;
    m_lo    = '0;
    m_err   = 1'b0;
    rst_n   = 1'b0;
    i_write = 1'b0;
    i_read  = 1'b0;
    i_data  = '0;
    @(posedge clk);
    do_reset();

    // four bundles, last on the fourth, reads held off
    for (int i = 0; i < 4; i++) b[i] = rnd_bundle();
    for (int i = 0; i < 4; i++) step(1'b1, i == 3, b[i], 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    drain();

    // odd run: third bundle padded, then a fresh pair proves the half flag cleared
    for (int i = 0; i < 5; i++) b[i] = rnd_bundle();
    step(1'b1, 1'b0, b[0], 1'b0);
    step(1'b1, 1'b0, b[1], 1'b0);
    step(1'b1, 1'b1, b[2], 1'b0);
    step(1'b1, 1'b0, b[3], 1'b0);
    step(1'b1, 1'b1, b[4], 1'b0);
    drain();

    // fill without reads: 17 pairs, the last one dropped
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(1'b1, 1'b0, rnd_bundle(), 1'b0);
      step(1'b1, ($urandom_range(0, 1) == 1), rnd_bundle(), 1'b0);
    end
    // completing write together with a read while full
    step(1'b1, 1'b0, rnd_bundle(), 1'b0);
    step(1'b1, 1'b1, rnd_bundle(), 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
    drain();

    // reset while a half bundle is pending
    step(1'b1, 1'b0, rnd_bundle(), 1'b0);
    step(1'b1, 1'b0, rnd_bundle(), 1'b0);
    step(1'b1, 1'b0, rnd_bundle(), 1'b0);
    @(posedge clk);
    #1;
    do_reset();
    step(1'b1, 1'b0, rnd_bundle(), 1'b0);
    step(1'b1, 1'b1, rnd_bundle(), 1'b0);
    drain();

    // continuous stream with random reads, including reads on an empty FIFO
    for (int i = 0; i < 40; i++)
      step(1'b1, ($urandom_range(0, 3) == 0), rnd_bundle(), ($urandom_range(0, 1) == 1));
    step(1'b1, 1'b1, rnd_bundle(), 1'b0);
    drain();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
